radix4_bf_pipe: RTL



---
 rtl/radix4_bf_pipe.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/radix4_bf_pipe.sv
// Pipelined radix-4 NTT/INTT butterfly: two CT (NTT) or GS (INTT) layers, LAT = 2*(MUL_LAT+1).
// Optional macro BF_INV_HALF_EN scales every GS butterfly output by 2^-1 mod Q.
module radix4_bf_pipe #(
    parameter int DATA_WIDTH = 14,
    parameter int Q          = 12289,
    parameter int MUL_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic [DATA_WIDTH-1:0] a1,
    input  logic [DATA_WIDTH-1:0] a2,
    input  logic [DATA_WIDTH-1:0] a3,
    input  logic [DATA_WIDTH-1:0] w1,
    input  logic [DATA_WIDTH-1:0] w2,
    input  logic [DATA_WIDTH-1:0] w3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y0,
    output logic [DATA_WIDTH-1:0] y1,
    output logic [DATA_WIDTH-1:0] y2,
    output logic [DATA_WIDTH-1:0] y3,
    output logic                  busy
);

    localparam int DW  = DATA_WIDTH;
    localparam int M   = MUL_LAT;
    localparam int LAT = 2 * (MUL_LAT + 1);
    localparam logic [DW:0]     QE = (DW + 1)'(Q);
    localparam logic [2*DW-1:0] QP = (2 * DW)'(Q);

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QE) s = s - QE;
        else         s = s;
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + QE - {1'b0, y};
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mod_mul(input logic [DW-1:0] x, input logic [DW-1:0] w);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, x} * {{DW{1'b0}}, w};
        p = p % QP;
        return p[DW-1:0];
    endfunction

    // GS output scaling: odd values borrow Q so the halving stays exact modulo Q.
    function automatic logic [DW-1:0] gs_scale(input logic [DW-1:0] x);
`ifdef BF_INV_HALF_EN
        logic [DW:0] s;
        if (x[0]) s = ({1'b0, x} + QE) >> 1;
        else      s = {1'b0, x} >> 1;
        return s[DW-1:0];
`else
        return x;
`endif
    endfunction

    function automatic int lpos(input int p);
        return (p > M) ? (p - M - 1) : p;
    endfunction

    logic [DW-1:0]  w_sd [LAT][4];
    logic [DW-1:0]  w_sw [LAT][3];
    logic [LAT-1:0] w_sm;
    logic [DW-1:0]  w_nd [LAT][4];
    logic [DW-1:0]  r_d  [LAT][4];
    logic [DW-1:0]  r_w  [LAT-1][3];
    logic [LAT-1:0] r_v;
    logic [LAT-2:0] r_m;
    logic           w_en;

    // Slot sources: position 0 takes the port beat, later positions the previous register.
    always_comb begin
        w_sd[0][0] = a0;
        w_sd[0][1] = a1;
        w_sd[0][2] = a2;
        w_sd[0][3] = a3;
        w_sw[0][0] = w1;
        w_sw[0][1] = w2;
        w_sw[0][2] = w3;
        w_sm[0]    = mode;
        for (int p = 1; p < LAT; p++) begin
            for (int l = 0; l < 4; l++) w_sd[p][l] = r_d[p-1][l];
            for (int k = 0; k < 3; k++) w_sw[p][k] = r_w[p-1][k];
            w_sm[p] = r_m[p-1];
        end
    end

    // Per-slot datapath: NTT multiplies at slot 0 and adds at slot M; INTT adds at 0, multiplies at 1.
    always_comb begin
        for (int p = 0; p < LAT; p++) begin
            for (int l = 0; l < 4; l++) w_nd[p][l] = w_sd[p][l];
            if (!w_sm[p]) begin
                if (lpos(p) == 0) begin
                    if (p <= M) begin
                        w_nd[p][2] = mod_mul(w_sd[p][2], w_sw[p][1]);
                        w_nd[p][3] = mod_mul(w_sd[p][3], w_sw[p][1]);
                    end else begin
                        w_nd[p][1] = mod_mul(w_sd[p][1], w_sw[p][0]);
                        w_nd[p][3] = mod_mul(w_sd[p][3], w_sw[p][2]);
                    end
                end else if (lpos(p) == M) begin
                    if (p <= M) begin
                        w_nd[p][0] = mod_add(w_sd[p][0], w_sd[p][2]);
                        w_nd[p][1] = mod_add(w_sd[p][1], w_sd[p][3]);
                        w_nd[p][2] = mod_sub(w_sd[p][0], w_sd[p][2]);
                        w_nd[p][3] = mod_sub(w_sd[p][1], w_sd[p][3]);
                    end else begin
                        w_nd[p][0] = mod_add(w_sd[p][0], w_sd[p][1]);
                        w_nd[p][1] = mod_sub(w_sd[p][0], w_sd[p][1]);
                        w_nd[p][2] = mod_add(w_sd[p][2], w_sd[p][3]);
                        w_nd[p][3] = mod_sub(w_sd[p][2], w_sd[p][3]);
                    end
                end else begin
                    for (int l = 0; l < 4; l++) w_nd[p][l] = w_sd[p][l];
                end
            end else begin
                if (lpos(p) == 0) begin
                    if (p <= M) begin
                        w_nd[p][0] = gs_scale(mod_add(w_sd[p][0], w_sd[p][1]));
                        w_nd[p][1] = gs_scale(mod_sub(w_sd[p][0], w_sd[p][1]));
                        w_nd[p][2] = gs_scale(mod_add(w_sd[p][2], w_sd[p][3]));
                        w_nd[p][3] = gs_scale(mod_sub(w_sd[p][2], w_sd[p][3]));
                    end else begin
                        w_nd[p][0] = gs_scale(mod_add(w_sd[p][0], w_sd[p][2]));
                        w_nd[p][1] = gs_scale(mod_add(w_sd[p][1], w_sd[p][3]));
                        w_nd[p][2] = gs_scale(mod_sub(w_sd[p][0], w_sd[p][2]));
                        w_nd[p][3] = gs_scale(mod_sub(w_sd[p][1], w_sd[p][3]));
                    end
                end else if (lpos(p) == 1) begin
                    if (p <= M) begin
                        w_nd[p][1] = mod_mul(w_sd[p][1], w_sw[p][0]);
                        w_nd[p][3] = mod_mul(w_sd[p][3], w_sw[p][2]);
                    end else begin
                        w_nd[p][2] = mod_mul(w_sd[p][2], w_sw[p][1]);
                        w_nd[p][3] = mod_mul(w_sd[p][3], w_sw[p][1]);
                    end
                end else begin
                    for (int l = 0; l < 4; l++) w_nd[p][l] = w_sd[p][l];
                end
            end
        end
    end

    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    // Pipeline registers: the whole chain freezes while the output beat is refused.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_m <= '0;
            for (int p = 0; p < LAT; p++)
                for (int l = 0; l < 4; l++) r_d[p][l] <= '0;
            for (int p = 0; p < LAT - 1; p++)
                for (int k = 0; k < 3; k++) r_w[p][k] <= '0;
        end else if (w_en) begin
            r_v <= {r_v[LAT-2:0], in_valid};
            r_m <= w_sm[LAT-2:0];
            for (int p = 0; p < LAT; p++)
                for (int l = 0; l < 4; l++) r_d[p][l] <= w_nd[p][l];
            for (int p = 0; p < LAT - 1; p++)
                for (int k = 0; k < 3; k++) r_w[p][k] <= w_sw[p][k];
        end
    end

    assign out_valid = r_v[LAT-1];
    assign y0        = r_d[LAT-1][0];
    assign y1        = r_d[LAT-1][1];
    assign y2        = r_d[LAT-1][2];
    assign y3        = r_d[LAT-1][3];
    assign busy      = |r_v;

endmodule
